sobel_window_buffer: RTL

SOBEL_WINDOW_BUFFER -- requirements
Module: sobel_window_buffer

---
 rtl/sobel_window_buffer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sobel_window_buffer.sv
// 3x3 sliding-window builder for a raster gray stream, using two line buffers.
// Optional macro SOBEL_WIN_POS_EN adds the registered window-centre outputs win_row_o/win_col_o.
module sobel_window_buffer #(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64,
  parameter int unsigned PX_W       = 8
) (
  input  logic                          clk_i,
  input  logic                          nreset_i,
  input  logic                          start_i,
  input  logic                          finish_i,
  input  logic                          px_valid_i,
  input  logic [PX_W-1:0]               px_gray_i,
  output logic                          win_valid_o,
  output logic [9*PX_W-1:0]             win_o,
  output logic                          busy_o
`ifdef SOBEL_WIN_POS_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col_o
`endif
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [PX_W-1:0] lb0 [IMG_WIDTH];
  logic [PX_W-1:0] lb1 [IMG_WIDTH];
  logic [PX_W-1:0] win [9];
  logic [PX_W-1:0] win_shift [9];
  logic [9*PX_W-1:0] win_packed;
  logic            accept;
  logic            col_last;
  logic            row_last;
  logic            win_hit;

  assign accept   = (state != IDLE) && px_valid_i && !finish_i;
  assign col_last = (col == CW'(IMG_WIDTH - 1));
  assign row_last = (row == RW'(IMG_HEIGHT - 1));
  assign win_hit  = (row >= RW'(2)) && (col >= CW'(2));

  // Window after one left shift, with the new right column taken from the line buffers.
  always_comb begin
    win_shift[0] = win[1];
    win_shift[1] = win[2];
    win_shift[2] = lb1[col];
    win_shift[3] = win[4];
    win_shift[4] = win[5];
    win_shift[5] = lb0[col];
    win_shift[6] = win[7];
    win_shift[7] = win[8];
    win_shift[8] = px_gray_i;
    win_packed   = '0;
    for (int k = 0; k < 9; k++) begin
      win_packed[9*PX_W-1-k*PX_W -: PX_W] = win_shift[k];
    end
  end

  // Line buffers carry no reset; a frame writes each column before reading it back.
  always_ff @(posedge clk_i) begin
    if (nreset_i && accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= px_gray_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      win_valid_o <= 1'b0;
      win_o       <= '0;
      busy_o      <= 1'b0;
      for (int k = 0; k < 9; k++) win[k] <= '0;
`ifdef SOBEL_WIN_POS_EN
      win_row_o   <= '0;
      win_col_o   <= '0;
`endif
    end else begin
      win_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= FILL;
            col    <= '0;
            row    <= '0;
            busy_o <= 1'b1;
          end
        end
        FILL, STREAM: begin
          if (finish_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (px_valid_i) begin
            for (int k = 0; k < 9; k++) win[k] <= win_shift[k];
            if (col_last) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (win_hit) begin
              win_valid_o <= 1'b1;
              win_o       <= win_packed;
`ifdef SOBEL_WIN_POS_EN
              win_row_o   <= row - RW'(1);
              win_col_o   <= col - CW'(1);
`endif
            end
            if (row_last && col_last) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else if (state == FILL && row == RW'(1) && col_last) begin
              state <= STREAM;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
